// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the chunked pipelined adder/subtractor.
package pipelined_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Operands must split into equal, non-empty chunks, one per stage.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle between producers, the adder pipe and its consumer.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] n2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;

  modport master (
    output in_valid, mode, n1, n2, cin, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, mode, n1, n2, cin, out_ready,
    output in_ready, out_valid, sum, ovf
  );

endinterface

// File: rtl/addsub_chunk_stage.sv
// One pipeline stage: resolves chunk IDX of the operands and forwards the carry,
// while the full operand and partial result words ride along as skew registers.
module addsub_chunk_stage
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_res,
  output logic             out_valid,
  output logic             out_carry,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_res
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LSB   = IDX * CHUNK;

  logic [CHUNK:0] part;

  always_comb begin
    part = {1'b0, in_a[LSB +: CHUNK]} + {1'b0, in_b[LSB +: CHUNK]} + {{CHUNK{1'b0}}, in_carry};
  end

  // Bubbles shift like real beats; everything freezes while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_carry <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_res   <= '0;
    end else if (en) begin
      out_valid               <= in_valid;
      out_carry               <= part[CHUNK];
      out_a                   <= in_a;
      out_b                   <= in_b;
      out_res                 <= in_res;
      out_res[LSB +: CHUNK]   <= part[CHUNK-1:0];
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Valid/ready pipelined adder/subtractor: STAGES chunk stages driven by a single
// global advance, so backpressure stalls the whole pipe in lockstep.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                clk,
  input logic                rst,
  pipelined_addsub_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             adv;
  logic             v [STAGES+1];
  logic             c [STAGES+1];
  logic [WIDTH-1:0] a [STAGES+1];
  logic [WIDTH-1:0] b [STAGES+1];
  logic [WIDTH-1:0] r [STAGES+1];

  assign adv          = !v[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  // Subtraction is n1 + ~n2 + 1, so mode only reshapes the stage-0 operand and carry.
  assign v[0] = bus.in_valid;
  assign a[0] = bus.n1;
  assign b[0] = (bus.mode == MODE_SUB) ? ~bus.n2 : bus.n2;
  assign c[0] = (bus.mode == MODE_SUB) ? 1'b1 : bus.cin;
  assign r[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_chunk_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (v[k]),
      .in_carry  (c[k]),
      .in_a      (a[k]),
      .in_b      (b[k]),
      .in_res    (r[k]),
      .out_valid (v[k+1]),
      .out_carry (c[k+1]),
      .out_a     (a[k+1]),
      .out_b     (b[k+1]),
      .out_res   (r[k+1])
    );
  end

  assign bus.out_valid = v[STAGES];
  assign bus.sum       = {c[STAGES], r[STAGES]};
  assign bus.ovf       = (a[STAGES][MSB] == b[STAGES][MSB]) && (r[STAGES][MSB] != a[STAGES][MSB]);

endmodule
